// File: rtl/etapa_salida.sv
// etapa_salida: sign correction with divide-by-zero/overflow flags for the signed divider,
// buffered in a 2-entry FIFO so the non-stallable pipeline can hand results to a slow consumer.
module etapa_salida #(
    parameter int AnchoDv = 15,
    parameter int AnchoQ  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             goIn,
    input  logic [AnchoQ:0]  quotMagIn,
    input  logic [AnchoDv:0] remMagIn,
    input  logic             negDivisorIn,
    input  logic             negDividendIn,
    input  logic             DivisorNoCeroIn,
    input  logic             readyIn,
    output logic             validOut,
    output logic [AnchoQ:0]  quotientOut,
    output logic [AnchoDv:0] remainderOut,
    output logic             divZeroOut,
    output logic             overflowOut,
    output logic             fullOut,
    output logic             lostOut
);
    localparam int EW = AnchoQ + AnchoDv + 4;
    localparam logic [AnchoQ:0] QLim = {1'b1, {AnchoQ{1'b0}}};

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   head_q, head_d, tail_q, tail_d, entry;
    logic            lost_q, lost_d;
    logic            neg_quot, ovf_c, push, pop, drop;
    logic [AnchoQ:0] quot_c;
    logic [AnchoDv:0] rem_c;

    // Entry layout: {quotient, remainder, divZero, overflow}
    always_comb begin
        neg_quot = negDivisorIn ^ negDividendIn;
        quot_c   = neg_quot ? -quotMagIn : quotMagIn;
        rem_c    = negDividendIn ? -remMagIn : remMagIn;
        ovf_c    = (!neg_quot & quotMagIn[AnchoQ]) | (neg_quot & (quotMagIn > QLim));
        entry    = DivisorNoCeroIn ? {quot_c, rem_c, 1'b0, ovf_c} : {{(EW-2){1'b0}}, 2'b10};
    end

    assign pop  = (state_q != EMPTY) & readyIn;
    assign push = goIn & ((state_q != FULL) | pop);
    assign drop = goIn & ~push;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        lost_d  = lost_q | drop;
        case (state_q)
            EMPTY: begin
                state_d = push ? ONE : EMPTY;
                head_d  = push ? entry : head_q;
            end
            ONE: begin
                state_d = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
                head_d  = pop ? (push ? entry : '0) : head_q;
                tail_d  = (push && !pop) ? entry : tail_q;
            end
            FULL: begin
                state_d = (pop && !push) ? ONE : FULL;
                head_d  = pop ? tail_q : head_q;
                tail_d  = pop ? (push ? entry : '0) : tail_q;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            lost_q  <= lost_d;
        end
    end

    assign validOut = (state_q != EMPTY);
    assign fullOut  = (state_q == FULL);
    assign lostOut  = lost_q;
    assign {quotientOut, remainderOut, divZeroOut, overflowOut} = head_q;
endmodule

// File: tb/tb_etapa_salida.sv
// tb_etapa_salida: directed vector table, drop/reset sequences and a randomized run
// against a queue-based reference model of etapa_salida.
module tb_etapa_salida;
    logic        clk = 1'b0, reset, goIn, negDivisorIn, negDividendIn, DivisorNoCeroIn, readyIn;
    logic [15:0] quotMagIn, remMagIn, quotientOut, remainderOut;
    logic        validOut, divZeroOut, overflowOut, fullOut, lostOut;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [15:0] qm, rm;
        logic        ndv, ndd, nz;
        logic [15:0] eq, er;
        logic        edz, eov;
    } vec_t;

    typedef struct {
        logic [15:0] q, r;
        logic        dz, ov;
    } exp_t;

    vec_t vecs[8];
    exp_t fifo[$];
    bit   lost_m;

    etapa_salida dut (
        .clk(clk), .reset(reset), .goIn(goIn), .quotMagIn(quotMagIn), .remMagIn(remMagIn),
        .negDivisorIn(negDivisorIn), .negDividendIn(negDividendIn),
        .DivisorNoCeroIn(DivisorNoCeroIn), .readyIn(readyIn), .validOut(validOut),
        .quotientOut(quotientOut), .remainderOut(remainderOut), .divZeroOut(divZeroOut),
        .overflowOut(overflowOut), .fullOut(fullOut), .lostOut(lostOut)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] qm, input logic [15:0] rm, input logic ndv,
                         input logic ndd, input logic nz);
        quotMagIn = qm; remMagIn = rm; negDivisorIn = ndv; negDividendIn = ndd; DivisorNoCeroIn = nz;
    endtask

    function automatic exp_t model(input logic [15:0] qm, input logic [15:0] rm,
                                   input logic ndv, input logic ndd, input logic nz);
        exp_t e;
        int   qv, rv;
        bit   nq;
        e = '{16'h0, 16'h0, 1'b1, 1'b0};
        if (nz) begin
            nq   = ndv ^ ndd;
            qv   = nq ? -int'(qm) : int'(qm);
            rv   = ndd ? -int'(rm) : int'(rm);
            e.q  = 16'(qv);
            e.r  = 16'(rv);
            e.dz = 1'b0;
            e.ov = nq ? (int'(qm) > 32768) : (int'(qm) >= 32768);
        end
        return e;
    endfunction

    task automatic check_model();
        exp_t h;
        h = (fifo.size() != 0) ? fifo[0] : '{16'h0, 16'h0, 1'b0, 1'b0};
        chk("rnd_valid", 32'(validOut), 32'(fifo.size() != 0));
        chk("rnd_full", 32'(fullOut), 32'(fifo.size() == 2));
        chk("rnd_lost", 32'(lostOut), 32'(lost_m));
        chk("rnd_q", 32'(quotientOut), 32'(h.q));
        chk("rnd_r", 32'(remainderOut), 32'(h.r));
        chk("rnd_dz", 32'(divZeroOut), 32'(h.dz));
        chk("rnd_ov", 32'(overflowOut), 32'(h.ov));
    endtask

    initial begin
        vecs[0] = '{16'd14, 16'd2, 1'b1, 1'b0, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
        vecs[1] = '{16'd14, 16'd2, 1'b0, 1'b1, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'd5, 16'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'd0, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'd0, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{16'h8001, 16'd0, 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{16'h7FFF, 16'd5, 1'b1, 1'b1, 1'b1, 16'h7FFF, 16'hFFFB, 1'b0, 1'b0};
        vecs[7] = '{16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};

        reset = 1'b0; goIn = 1'b0; readyIn = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(); step();
        chk("rst_valid", 32'(validOut), 32'd0);
        chk("rst_full", 32'(fullOut), 32'd0);
        chk("rst_lost", 32'(lostOut), 32'd0);
        chk("rst_q", 32'(quotientOut), 32'd0);
        chk("rst_r", 32'(remainderOut), 32'd0);
        chk("rst_dz", 32'(divZeroOut), 32'd0);
        chk("rst_ov", 32'(overflowOut), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].qm, vecs[i].rm, vecs[i].ndv, vecs[i].ndd, vecs[i].nz);
            goIn = 1'b1; readyIn = 1'b0;
            step();
            goIn = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(validOut), 32'd1);
            chk($sformatf("vec%0d_full", i), 32'(fullOut), 32'd0);
            chk($sformatf("vec%0d_q", i), 32'(quotientOut), 32'(vecs[i].eq));
            chk($sformatf("vec%0d_r", i), 32'(remainderOut), 32'(vecs[i].er));
            chk($sformatf("vec%0d_dz", i), 32'(divZeroOut), 32'(vecs[i].edz));
            chk($sformatf("vec%0d_ov", i), 32'(overflowOut), 32'(vecs[i].eov));
            readyIn = 1'b1;
            step();
            readyIn = 1'b0;
            chk($sformatf("vec%0d_popped", i), 32'(validOut), 32'd0);
            chk($sformatf("vec%0d_zero_q", i), 32'(quotientOut), 32'd0);
        end

        // A, B, C with no consumer: C must be dropped
        for (int i = 1; i <= 3; i++) begin
            drive(16'(i), 16'(i), 1'b0, 1'b0, 1'b1);
            goIn = 1'b1;
            chk($sformatf("abc_lost_before%0d", i), 32'(lostOut), 32'd0);
            step();
        end
        goIn = 1'b0;
        chk("abc_full", 32'(fullOut), 32'd1);
        chk("abc_lost", 32'(lostOut), 32'd1);
        chk("abc_headA", 32'(quotientOut), 32'd1);
        readyIn = 1'b1;
        step();
        chk("abc_headB_valid", 32'(validOut), 32'd1);
        chk("abc_headB", 32'(quotientOut), 32'd2);
        chk("abc_notfull", 32'(fullOut), 32'd0);
        step();
        chk("abc_empty", 32'(validOut), 32'd0);
        chk("abc_lost_sticky", 32'(lostOut), 32'd1);
        readyIn = 1'b0;

        goIn = 1'b1;
        step(); step();
        goIn = 1'b0;
        chk("ar_full", 32'(fullOut), 32'd1);
        #3 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(validOut), 32'd0);
        chk("ar_full0", 32'(fullOut), 32'd0);
        chk("ar_lost0", 32'(lostOut), 32'd0);
        chk("ar_q0", 32'(quotientOut), 32'd0);
        step();
        reset = 1'b1;

        fifo.delete();
        lost_m = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [15:0] qm;
            logic        p, u;
            case ($urandom_range(0, 4))
                0: qm = 16'h8000;
                1: qm = 16'h8001;
                2: qm = 16'h7FFF;
                3: qm = 16'h0000;
                default: qm = 16'($urandom);
            endcase
            drive(qm, 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0);
            goIn = ($urandom_range(0, 3) != 0);
            readyIn = ($urandom_range(0, 1) != 0);
            p = (fifo.size() != 0) && readyIn;
            u = goIn && ((fifo.size() < 2) || p);
            if (goIn && !u) lost_m = 1'b1;
            step();
            if (p) void'(fifo.pop_front());
            if (u) fifo.push_back(model(quotMagIn, remMagIn, negDivisorIn, negDividendIn, DivisorNoCeroIn));
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
